// File: rtl/csc_pkg.sv
// Shared types and matrix coefficients for the RGB->YPbPr converter.
// Coefficients are x256 fixed point, 9-bit signed, one row per output channel.
package csc_pkg;

  typedef enum logic [1:0] {
    CSC_RGB = 2'd0,
    CSC_601 = 2'd1,
    CSC_709 = 2'd2
  } csc_mode_e;

  localparam int LAT = 3;
  localparam int CW  = 9;

  typedef logic signed [CW-1:0] coef_t;

  typedef struct packed {
    coef_t r;
    coef_t g;
    coef_t b;
  } coef_row_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic csync;
    logic de;
  } ctl_t;

  localparam coef_row_t Y601  = '{r:  9'sd77,  g:  9'sd150, b:  9'sd29};
  localparam coef_row_t PB601 = '{r: -9'sd43,  g: -9'sd85,  b:  9'sd128};
  localparam coef_row_t PR601 = '{r:  9'sd128, g: -9'sd107, b: -9'sd21};
  localparam coef_row_t Y709  = '{r:  9'sd54,  g:  9'sd183, b:  9'sd19};
  localparam coef_row_t PB709 = '{r: -9'sd29,  g: -9'sd99,  b:  9'sd128};
  localparam coef_row_t PR709 = '{r:  9'sd128, g: -9'sd116, b: -9'sd12};

  // Code 3 is reserved and behaves as bypass.
  function automatic csc_mode_e csc_map_mode(input logic [1:0] m);
    case (m)
      2'd1:    return CSC_601;
      2'd2:    return CSC_709;
      default: return CSC_RGB;
    endcase
  endfunction

  // Row 0 = Y, 1 = Pb, 2 = Pr. Bypass gets the 601 rows; their result is discarded.
  function automatic coef_row_t csc_row(input csc_mode_e m, input logic [1:0] row);
    coef_row_t c;
    if (m == CSC_709) begin
      case (row)
        2'd0:    c = Y709;
        2'd1:    c = PB709;
        default: c = PR709;
      endcase
    end else begin
      case (row)
        2'd0:    c = Y601;
        2'd1:    c = PB601;
        default: c = PR601;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/csc_channel_mac.sv
// One output row of the colour matrix: three signed products, sum with offset and
// rounding, then a combinational >>8 and clamp to the DW-bit output range.
module csc_channel_mac
  import csc_pkg::*;
#(
  parameter int DW     = 8,
  parameter bit CHROMA = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] r,
  input  logic [DW-1:0] g,
  input  logic [DW-1:0] b,
  input  coef_row_t     coef,
  output logic [DW-1:0] res
);

  localparam int AW = DW + 10;
  localparam logic signed [AW-1:0] RND  = AW'(128);
  // Chroma is centred on mid-scale, pre-shifted into the x256 domain.
  localparam logic signed [AW-1:0] OFFS = CHROMA ? (AW'(1) <<< (DW + 7)) : AW'(0);

  logic signed [AW-1:0] p_r, p_g, p_b;
  logic signed [AW-1:0] acc;
  logic signed [DW+1:0] sh;

  function automatic logic signed [AW-1:0] mul(input logic [DW-1:0] x, input coef_t c);
    logic signed [AW-1:0] xs;
    logic signed [AW-1:0] cs;
    xs = $signed({{(AW-DW){1'b0}}, x});
    cs = $signed({{(AW-CW){c[CW-1]}}, c});
    return xs * cs;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p_r <= '0;
      p_g <= '0;
      p_b <= '0;
      acc <= '0;
    end else begin
      p_r <= mul(r, coef.r);
      p_g <= mul(g, coef.g);
      p_b <= mul(b, coef.b);
      acc <= p_r + p_g + p_b + OFFS + RND;
    end
  end

  always_comb begin
    sh  = (DW+2)'(acc >>> 8);
    res = sh[DW-1:0];
    if (sh[DW+1])
      res = '0;
    else if (sh[DW])
      res = '1;
  end

endmodule

// File: rtl/csc_ypbpr_pipe.sv
// RGB->YPbPr/RGB converter with frame-safe mode switching, three-cycle latency in every
// mode, blank forcing and matched sync/de delay.
module csc_ypbpr_pipe
  import csc_pkg::*;
#(
  parameter int         DW           = 8,
  parameter logic [1:0] DEFAULT_MODE = 2'd1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      mode,
  input  logic            hsync,
  input  logic            vsync,
  input  logic            csync,
  input  logic            de,
  input  logic [3*DW-1:0] din,
  output logic [3*DW-1:0] dout,
  output logic            hsync_o,
  output logic            vsync_o,
  output logic            csync_o,
  output logic            de_o,
  output logic [1:0]      mode_act
);

  localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};

  logic            vsync_q;
  csc_mode_e       mode_r, mode_eff, mode_s1, mode_s2;
  ctl_t            ctl_in, ctl_s1, ctl_s2;
  logic [3*DW-1:0] din_s1, din_s2;
  coef_row_t       coef_y, coef_pb, coef_pr;
  logic [DW-1:0]   y_c, pb_c, pr_c;
  logic [DW-1:0]   din_r, din_g, din_b;

  assign din_r    = din[3*DW-1:2*DW];
  assign din_g    = din[2*DW-1:DW];
  assign din_b    = din[DW-1:0];
  assign ctl_in   = '{hsync: hsync, vsync: vsync, csync: csync, de: de};
  assign mode_act = mode_r;

  // The pixel arriving with the vsync rising edge already uses the newly requested mode.
  always_comb begin
    mode_eff = mode_r;
    if (vsync && !vsync_q)
      mode_eff = csc_map_mode(mode);
    coef_y  = csc_row(mode_eff, 2'd0);
    coef_pb = csc_row(mode_eff, 2'd1);
    coef_pr = csc_row(mode_eff, 2'd2);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vsync_q <= 1'b0;
      mode_r  <= csc_map_mode(DEFAULT_MODE);
      mode_s1 <= CSC_RGB;
      mode_s2 <= CSC_RGB;
      ctl_s1  <= '0;
      ctl_s2  <= '0;
      din_s1  <= '0;
      din_s2  <= '0;
    end else begin
      vsync_q <= vsync;
      mode_r  <= mode_eff;
      mode_s1 <= mode_eff;
      mode_s2 <= mode_s1;
      ctl_s1  <= ctl_in;
      ctl_s2  <= ctl_s1;
      din_s1  <= din;
      din_s2  <= din_s1;
    end
  end

  csc_channel_mac #(.DW(DW), .CHROMA(1'b0)) u_y (
    .clk     (clk),
    .reset_n (reset_n),
    .r       (din_r),
    .g       (din_g),
    .b       (din_b),
    .coef    (coef_y),
    .res     (y_c)
  );

  csc_channel_mac #(.DW(DW), .CHROMA(1'b1)) u_pb (
    .clk     (clk),
    .reset_n (reset_n),
    .r       (din_r),
    .g       (din_g),
    .b       (din_b),
    .coef    (coef_pb),
    .res     (pb_c)
  );

  csc_channel_mac #(.DW(DW), .CHROMA(1'b1)) u_pr (
    .clk     (clk),
    .reset_n (reset_n),
    .r       (din_r),
    .g       (din_g),
    .b       (din_b),
    .coef    (coef_pr),
    .res     (pr_c)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dout    <= '0;
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
      csync_o <= 1'b0;
      de_o    <= 1'b0;
    end else begin
      hsync_o <= ctl_s2.hsync;
      vsync_o <= ctl_s2.vsync;
      csync_o <= ctl_s2.csync;
      de_o    <= ctl_s2.de;
      if (mode_s2 == CSC_RGB)
        dout <= ctl_s2.de ? din_s2 : '0;
      else if (!ctl_s2.de)
        dout <= {MID, {DW{1'b0}}, MID};
      else
        dout <= {pr_c, y_c, pb_c};
    end
  end

endmodule

// File: tb/tb_csc_ypbpr_pipe.sv
// Self-checking bench for csc_ypbpr_pipe (DW=8): directed vectors plus randomized traffic
// against an integer-arithmetic colour model with a three-deep expectation queue.
module tb_csc_ypbpr_pipe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        hsync = 1'b0, vsync = 1'b0, csync = 1'b0, de = 1'b0;
  logic [23:0] din = 24'h0;
  logic [23:0] dout;
  logic        hsync_o, vsync_o, csync_o, de_o;
  logic [1:0]  mode_act;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   mdl_mode = 1;
  logic mdl_vq   = 1'b0;

  typedef struct packed {
    logic [23:0] d;
    logic [3:0]  c;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  csc_ypbpr_pipe #(.DW(8), .DEFAULT_MODE(2'd1)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .mode     (mode),
    .hsync    (hsync),
    .vsync    (vsync),
    .csync    (csync),
    .de       (de),
    .din      (din),
    .dout     (dout),
    .hsync_o  (hsync_o),
    .vsync_o  (vsync_o),
    .csync_o  (csync_o),
    .de_o     (de_o),
    .mode_act (mode_act)
  );

  // Expected output pixel {Pr,Y,Pb} or {R,G,B} from plain integer matrix arithmetic.
  function automatic logic [23:0] ref_pix(input int m, input logic dv, input logic [23:0] px);
    int rgb[3];
    int k[9];
    int v;
    logic [7:0] o[3];
    rgb[0] = int'(px[23:16]);
    rgb[1] = int'(px[15:8]);
    rgb[2] = int'(px[7:0]);
    if (m == 0) return dv ? px : 24'h0;
    if (!dv) return 24'h800080;
    if (m == 2) k = '{54, 183, 19, -29, -99, 128, 128, -116, -12};
    else        k = '{77, 150, 29, -43, -85, 128, 128, -107, -21};
    for (int row = 0; row < 3; row++) begin
      v = k[row*3]*rgb[0] + k[row*3+1]*rgb[1] + k[row*3+2]*rgb[2] + 128;
      if (row != 0) v = v + 128*256;
      v = v >>> 8;
      if (v < 0)   v = 0;
      if (v > 255) v = 255;
      o[row] = 8'(v);
    end
    return {o[2], o[0], o[1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: model the pixel presented now, advance, compare the pixel now leaving the pipe.
  task automatic step(input string tag);
    exp_t e;
    if (!reset_n) begin
      @(posedge clk); #1;
      mdl_mode = 1;
      mdl_vq   = 1'b0;
      q.delete();
      q.push_back('0);
      q.push_back('0);
      chk({tag, "/rst_dout"}, 32'(dout), 32'h0);
      chk({tag, "/rst_ctl"}, 32'({hsync_o, vsync_o, csync_o, de_o}), 32'h0);
      chk({tag, "/rst_mode"}, 32'(mode_act), 32'd1);
    end else begin
      if (vsync && !mdl_vq) mdl_mode = (mode == 2'd3) ? 0 : int'(mode);
      mdl_vq = vsync;
      e.d = ref_pix(mdl_mode, de, din);
      e.c = {hsync, vsync, csync, de};
      q.push_back(e);
      @(posedge clk); #1;
      if (q.size() >= 3) begin
        e = q.pop_front();
        chk({tag, "/dout"}, 32'(dout), 32'(e.d));
        chk({tag, "/ctl"}, 32'({hsync_o, vsync_o, csync_o, de_o}), 32'(e.c));
      end else begin
        chk({tag, "/qdepth"}, 32'(q.size()), 32'd3);
      end
      chk({tag, "/mode_act"}, 32'(mode_act), 32'(mdl_mode));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with toggling inputs, including a vsync rise that must be ignored.
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mode  = 2'($urandom_range(0, 3));
      hsync = 1'($urandom);
      vsync = (i == 2);
      csync = 1'($urandom);
      de    = 1'($urandom);
      din   = 24'($urandom);
      step("reset");
    end

    reset_n = 1'b1;
    vsync = 1'b0; hsync = 1'b0; csync = 1'b0; de = 1'b1; mode = 2'd1;
    din = 24'hFFFFFF; step("601_white");
    din = 24'h000000; step("601_black");
    din = 24'hFF0000; step("601_red");
    chk("601_white_exp", 32'(dout), 32'h80FF80);
    step("601_red2");
    chk("601_black_exp", 32'(dout), 32'h800080);
    step("601_red3");
    chk("601_red_exp", 32'(dout), 32'hFF4D55);

    // 709 latched on vsync rise; the edge pixel already uses it.
    mode = 2'd2; vsync = 1'b1; din = 24'h0000FF;
    step("709_edge");
    step("709_b");
    step("709_c");
    chk("709_blue_exp", 32'(dout), 32'h7413FF);
    chk("709_mode_act", 32'(mode_act), 32'd2);

    // Mode input changes with vsync held high: no edge, no switch.
    mode = 2'd1;
    step("hold_a");
    step("hold_b");
    step("hold_c");
    chk("hold_dout", 32'(dout), 32'h7413FF);
    chk("hold_mode_act", 32'(mode_act), 32'd2);
    vsync = 1'b0; step("vs_low");
    vsync = 1'b1; step("vs_rise");
    chk("relatch_601", 32'(mode_act), 32'd1);

    // Blank forcing in 601, then in bypass; sync delay in bypass.
    de = 1'b0; din = 24'hFFFFFF;
    step("blank_a");
    step("blank_b");
    step("blank_c");
    chk("blank_601", 32'(dout), 32'h800080);
    vsync = 1'b0; step("vs_low2");
    mode = 2'd0; vsync = 1'b1; step("bypass_edge");
    step("bypass_b");
    step("bypass_c");
    chk("blank_bypass", 32'(dout), 32'h000000);
    chk("bypass_mode_act", 32'(mode_act), 32'd0);
    de = 1'b1; din = 24'h123456; hsync = 1'b1;
    step("byp_pix");
    hsync = 1'b0; din = 24'h000000;
    step("byp_b");
    step("byp_c");
    chk("bypass_pix", 32'(dout), 32'h123456);
    chk("hsync_lat3", 32'(hsync_o), 32'd1);
    step("byp_d");
    chk("hsync_lat3_end", 32'(hsync_o), 32'd0);

    // Randomized traffic with mode requests, frame edges and occasional mid-frame reset.
    for (int i = 0; i < 400; i++) begin
      reset_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      if (i % 11 == 0) mode = 2'($urandom_range(0, 3));
      vsync = ((i % 37) < 3);
      hsync = 1'($urandom);
      csync = 1'($urandom);
      de    = ($urandom_range(0, 3) != 0);
      din   = 24'($urandom);
      step(reset_n ? "rand" : "rand_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
